pipelined_ctrl_decoder: RTL

//  Registered main-control decoder stage for the RV32I+F core: decodes op/funct7 into the control bundle
//  (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump, FP, FPlw, FPsw) behind a valid/ready handshake.

---
 rtl/riscv_ctrl_pkg.sv | 39 +++
 rtl/ctrl_decode_table.sv | 74 +++++++
 rtl/pipelined_ctrl_decoder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I+F main-control decoder stage.
//   - Opcode and FP sub-op (funct7[6:2]) codes
//   - Control bundle layout (11 bits) and FSM state encoding
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_FLW = 7'b0000111;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_FSW = 7'b0100111;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_FP  = 7'b1010011;
  localparam logic [6:0] OP_NOP = 7'b0000000;

  localparam logic [4:0] F7_FMUL  = 5'b00010;
  localparam logic [4:0] F7_FDIV  = 5'b00011;
  localparam logic [4:0] F7_FSQRT = 5'b01011;

  localparam int unsigned BundleW = 11;

  // Field order matches the decode table: RegWrite_ImmSrc_ALUSrc_MemWrite_ResultSrc_Branch_ALUOp_Jump
  typedef struct packed {
    logic       regwrite;
    logic [1:0] immsrc;
    logic       alusrc;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       branch;
    logic [1:0] aluop;
    logic       jump;
  } ctrl_t;

  typedef enum logic [1:0] {LatNone, LatMul, LatDiv, LatSqrt} lat_sel_e;

  typedef enum logic [1:0] {StIdle, StHold, StFpWait} state_e;

endpackage

// File: rtl/ctrl_decode_table.sv
// Pure combinational op/funct7 -> control bundle lookup.
//   op, funct7    : instruction fields
//   ctrl          : 11-bit control bundle (all zero for bubble/unknown)
//   fp/fplw/fpsw  : FP datapath flags
//   is_multi      : op is a multi-cycle FP candidate (fmul/fdiv/fsqrt)
//   lat_sel       : which latency parameter applies
//   illegal_op    : opcode is neither implemented nor a bubble
module ctrl_decode_table
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       fp,
  output logic       fplw,
  output logic       fpsw,
  output logic       is_multi,
  output lat_sel_e   lat_sel,
  output logic       illegal_op
);

  logic [1:0] unused_f7;
  assign unused_f7 = funct7[1:0];

  always_comb begin
    ctrl       = '0;
    fp         = 1'b0;
    fplw       = 1'b0;
    fpsw       = 1'b0;
    is_multi   = 1'b0;
    lat_sel    = LatNone;
    illegal_op = 1'b0;
    case (op)
      OP_LW:  ctrl = 11'b1_00_1_0_01_0_00_0;
      OP_FLW: begin
        ctrl = 11'b1_00_1_0_01_0_00_0;
        fp   = 1'b1;
        fplw = 1'b1;
      end
      OP_SW:  ctrl = 11'b0_01_1_1_00_0_00_0;
      OP_FSW: begin
        ctrl = 11'b0_01_1_1_00_0_00_0;
        fp   = 1'b1;
        fpsw = 1'b1;
      end
      OP_R:   ctrl = 11'b1_00_0_0_00_0_10_0;
      OP_BEQ: ctrl = 11'b0_10_0_0_00_1_01_0;
      OP_I:   ctrl = 11'b1_00_1_0_00_0_10_0;
      OP_JAL: ctrl = 11'b1_11_0_0_10_0_00_1;
      OP_FP: begin
        ctrl = 11'b1_00_0_0_00_0_10_0;
        fp   = 1'b1;
        case (funct7[6:2])
          F7_FMUL: begin
            is_multi = 1'b1;
            lat_sel  = LatMul;
          end
          F7_FDIV: begin
            is_multi = 1'b1;
            lat_sel  = LatDiv;
          end
          F7_FSQRT: begin
            is_multi = 1'b1;
            lat_sel  = LatSqrt;
          end
          default: ;
        endcase
      end
      OP_NOP: ;
      default: illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_ctrl_decoder.sv
// Registered main-control decoder stage with valid/ready handshake and
// multi-cycle FP issue (fmul/fdiv/fsqrt hold the stage for FP_*_LAT cycles).
// Optional feature macro: ILLEGAL_TRAP_EN -- when defined, an unimplemented
// opcode sets a sticky `illegal` flag (cleared by reset or flush); otherwise
// `illegal` is tied 0 and such opcodes pass as bubbles.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready, op, funct7 : upstream handshake and instruction fields
//   flush                          : kill held/pending instruction
//   out_valid/out_ready            : downstream handshake
//   regwrite..fpsw                 : control bundle (0 whenever out_valid=0)
//   fp_busy                        : multi-cycle FP op counting
//   illegal                        : sticky unimplemented-opcode flag
module pipelined_ctrl_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned FP_MUL_LAT  = 3,
  parameter int unsigned FP_DIV_LAT  = 8,
  parameter int unsigned FP_SQRT_LAT = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  input  logic       flush,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       regwrite,
  output logic       alusrc,
  output logic       memwrite,
  output logic       branch,
  output logic       jump,
  output logic       fp,
  output logic       fplw,
  output logic       fpsw,
  output logic [1:0] immsrc,
  output logic [1:0] resultsrc,
  output logic [1:0] aluop,
  output logic       fp_busy,
  output logic       illegal
);

  localparam int unsigned MaxLat01 = (FP_MUL_LAT > FP_DIV_LAT) ? FP_MUL_LAT : FP_DIV_LAT;
  localparam int unsigned MaxLat   = (MaxLat01 > FP_SQRT_LAT) ? MaxLat01 : FP_SQRT_LAT;
  localparam int unsigned CntW     = $clog2(MaxLat + 1);

  ctrl_t    dec_ctrl;
  logic     dec_fp, dec_fplw, dec_fpsw, dec_multi, dec_illegal;
  lat_sel_e dec_lat_sel;

  ctrl_decode_table u_table (
    .op         (op),
    .funct7     (funct7),
    .ctrl       (dec_ctrl),
    .fp         (dec_fp),
    .fplw       (dec_fplw),
    .fpsw       (dec_fpsw),
    .is_multi   (dec_multi),
    .lat_sel    (dec_lat_sel),
    .illegal_op (dec_illegal)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  ctrl_t           bundle_q, bundle_d;
  logic [2:0]      flags_q, flags_d;  // {fp, fplw, fpsw}

  logic            accept;
  int unsigned     sel_lat;
  logic            go_multi;

  always_comb begin
    case (dec_lat_sel)
      LatMul:  sel_lat = FP_MUL_LAT;
      LatDiv:  sel_lat = FP_DIV_LAT;
      LatSqrt: sel_lat = FP_SQRT_LAT;
      default: sel_lat = 1;
    endcase
  end

  // A latency of 1 collapses to the ordinary single-cycle path.
  assign go_multi = dec_multi && (sel_lat > 1);

  assign in_ready = !flush && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bundle_d = bundle_q;
    flags_d  = flags_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (accept) begin
      bundle_d = dec_ctrl;
      flags_d  = {dec_fp, dec_fplw, dec_fpsw};
      if (go_multi) begin
        state_d = StFpWait;
        cnt_d   = CntW'(sel_lat - 1);
      end else begin
        state_d = StHold;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        StHold: begin
          if (out_ready) state_d = StIdle;
        end
        StFpWait: begin
          if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
          if (cnt_q <= CntW'(1)) state_d = StHold;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bundle_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bundle_q <= bundle_d;
      flags_q  <= flags_d;
    end
  end

  ctrl_t      ctrl_out;
  logic [2:0] flags_out;

  assign out_valid = (state_q == StHold);
  assign fp_busy   = (state_q == StFpWait);
  assign ctrl_out  = out_valid ? bundle_q : '0;
  assign flags_out = out_valid ? flags_q : 3'b000;

  assign regwrite  = ctrl_out.regwrite;
  assign immsrc    = ctrl_out.immsrc;
  assign alusrc    = ctrl_out.alusrc;
  assign memwrite  = ctrl_out.memwrite;
  assign resultsrc = ctrl_out.resultsrc;
  assign branch    = ctrl_out.branch;
  assign aluop     = ctrl_out.aluop;
  assign jump      = ctrl_out.jump;
  assign fp        = flags_out[2];
  assign fplw      = flags_out[1];
  assign fpsw      = flags_out[0];

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (flush) illegal_d = 1'b0;
    else if (accept && dec_illegal) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign illegal        = 1'b0;
`endif

endmodule
